// File: rtl/ccff_chain_loader_if.sv
// rtl/ccff_chain_loader_if.sv - bitstream word handshake between source and chain loader
interface ccff_chain_loader_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] cfg_word;
  logic              cfg_valid;
  logic              cfg_ready;

  modport master (output cfg_word, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_word, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serialises bitstream words onto a ccff chain head with clock-gate enable
// Optional CRC readback verify of the chain: define CCFF_CHAIN_LOADER_READBACK_EN.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 10,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic               prog_clk,
  input  logic               prog_resetn,
  input  logic               start,
  ccff_chain_loader_if.slave cfg,
  output logic               ccff_head,
  input  logic               ccff_tail,
  output logic               chain_clk_en,
  output logic               busy,
  output logic               done,
  output logic               error
);
  localparam int N_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int SC_W    = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LEN    = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] NWORDS = CNT_W'(N_WORDS);
  localparam logic [SC_W-1:0]  FULL   = SC_W'(WORD_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    VERIFY = 2'd2,
`endif
    DONE   = 2'd3
  } state_t;

  state_t             state, state_next;
  logic [WORD_W-1:0]  sreg, pf_word;
  logic [SC_W-1:0]    sreg_cnt;
  logic               pf_valid;
  logic [CNT_W-1:0]   bit_cnt, word_cnt;
  logic               head_r, en_r, done_r;
  logic               start_load, last_bit, emit, pf_drain, ready, accept;
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  logic [15:0]        crc_load, crc_rb, crc_rb_next;
  logic [CNT_W-1:0]   vrf_cnt;
  logic               error_r;
`endif

  always_ff @(posedge prog_clk or negedge prog_resetn) begin
    if (!prog_resetn) state <= IDLE;
    else              state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_load = 1'b0;
    busy       = 1'b0;
    emit       = 1'b0;
    pf_drain   = 1'b0;
    ready      = 1'b0;
    last_bit   = (bit_cnt == LEN);
    case (state)
      IDLE, DONE: begin
        state_next = IDLE;
        if (start) begin
          state_next = LOAD;
          start_load = 1'b1;
        end
      end
      LOAD: begin
        busy = 1'b1;
        emit = !last_bit && (sreg_cnt != '0);
        // prefetch refills the shift register on the cycle it runs dry, keeping one bit per cycle
        pf_drain = pf_valid && ((sreg_cnt == '0) || (emit && sreg_cnt == SC_W'(1)));
        ready    = (word_cnt != NWORDS) && (!pf_valid || pf_drain);
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
        if (last_bit) state_next = VERIFY;
`else
        if (last_bit) state_next = DONE;
`endif
      end
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
      VERIFY: begin
        busy = 1'b1;
        if (vrf_cnt == LEN - CNT_W'(1)) state_next = DONE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  assign accept        = ready && cfg.cfg_valid;
  assign cfg.cfg_ready = ready;
  assign done          = done_r;

  always_ff @(posedge prog_clk or negedge prog_resetn) begin
    if (!prog_resetn) begin
      sreg     <= '0;
      pf_word  <= '0;
      sreg_cnt <= '0;
      pf_valid <= 1'b0;
      bit_cnt  <= '0;
      word_cnt <= '0;
      head_r   <= 1'b0;
      en_r     <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      en_r <= emit;
      if (start_load) begin
        sreg_cnt <= '0;
        pf_valid <= 1'b0;
        bit_cnt  <= '0;
        word_cnt <= '0;
        done_r   <= 1'b0;
      end else begin
        if (emit) begin
          head_r   <= sreg[WORD_W-1];
          sreg     <= sreg << 1;
          sreg_cnt <= sreg_cnt - SC_W'(1);
          bit_cnt  <= bit_cnt + CNT_W'(1);
        end
        if (pf_drain) begin
          sreg     <= pf_word;
          sreg_cnt <= FULL;
          pf_valid <= 1'b0;
        end
        if (accept) begin
          pf_word  <= cfg.cfg_word;
          pf_valid <= 1'b1;
          word_cnt <= word_cnt + CNT_W'(1);
        end
        if (state_next == DONE) done_r <= 1'b1;
      end
    end
  end

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  assign crc_rb_next = crc_step(crc_rb, ccff_tail);

  always_ff @(posedge prog_clk or negedge prog_resetn) begin
    if (!prog_resetn) begin
      crc_load <= 16'hFFFF;
      crc_rb   <= 16'hFFFF;
      vrf_cnt  <= '0;
      error_r  <= 1'b0;
    end else if (start_load) begin
      crc_load <= 16'hFFFF;
      crc_rb   <= 16'hFFFF;
      vrf_cnt  <= '0;
      error_r  <= 1'b0;
    end else begin
      if (emit) crc_load <= crc_step(crc_load, sreg[WORD_W-1]);
      if (state == VERIFY) begin
        crc_rb  <= crc_rb_next;
        vrf_cnt <= vrf_cnt + CNT_W'(1);
        if (state_next == DONE) error_r <= (crc_rb_next != crc_load);
      end
    end
  end

  // tail fed straight back to head so the chain is restored after a full rotation
  assign ccff_head    = (state == VERIFY) ? ccff_tail : head_r;
  assign chain_clk_en = en_r | (state == VERIFY);
  assign error        = error_r;
`else
  logic unused_tail;
  assign unused_tail  = ccff_tail;
  assign ccff_head    = head_r;
  assign chain_clk_en = en_r;
  assign error        = 1'b0;
`endif
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - scoreboard bench for ccff_chain_loader with a shift-chain model
module tb_ccff_chain_loader;
  localparam int L  = 10;
  localparam int W  = 8;
  localparam int NW = (L + W - 1) / W;
  typedef logic [W-1:0] words_t [NW];

  logic clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic head, tail, en, busy, done, error;
  always #5 clk = ~clk;

  ccff_chain_loader_if #(.WORD_W(W)) cfg ();
  ccff_chain_loader #(.CHAIN_LEN(L), .WORD_W(W), .CNT_W(16)) dut (
    .prog_clk(clk), .prog_resetn(resetn), .start(start), .cfg(cfg),
    .ccff_head(head), .ccff_tail(tail), .chain_clk_en(en),
    .busy(busy), .done(done), .error(error)
  );

  logic [L-1:0] chain = '0;
  logic [L-1:0] exp_chain = '0;
  int  shift_n = 0, flip_at = -1, cyc = 0, acc_n = 0;
  int  npop = 0, pop_base = 0, acc_base = 0, total = 0, bad = 0;
  int  pop_cyc [0:4095];
  bit  exp_q [$];
  bit  exp_err = 1'b0, chk_span = 1'b0, done_q = 1'b0;

  assign tail = chain[L-1] ^ (flip_at == shift_n);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cfg.cfg_valid && cfg.cfg_ready) acc_n <= acc_n + 1;
    if (en) begin
      chain   <= {chain[L-2:0], head};
      shift_n <= shift_n + 1;
    end
  end

  always @(negedge clk) begin
    if (!resetn) begin
      total++;
      if ({head, en, busy, done, error, cfg.cfg_ready} !== 6'b0) begin
        bad++;
        $display("FAIL reset_outputs: got %b want 000000", {head, en, busy, done, error, cfg.cfg_ready});
      end
    end
    if (en) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL head_extra: shift %0d got head=%0b want no shift", npop, head);
      end else begin
        bit e;
        e = exp_q.pop_front();
        if (head !== e) begin
          bad++;
          $display("FAIL head_bit: shift %0d got %0b want %0b", npop, head, e);
        end
      end
      pop_cyc[npop % 4096] = cyc;
      npop++;
    end
    if (resetn && done && !done_q) begin
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL done_busy: got %0b want 0", busy); end
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL done_left: got %0d bits pending want 0", exp_q.size()); end
      total++;
      if (error !== exp_err) begin bad++; $display("FAIL done_error: got %0b want %0b", error, exp_err); end
      total++;
      if (chain !== exp_chain) begin bad++; $display("FAIL chain: got %b want %b", chain, exp_chain); end
      total++;
      if (acc_n - acc_base != NW) begin bad++; $display("FAIL words_accepted: got %0d want %0d", acc_n - acc_base, NW); end
      if (chk_span) begin
        total++;
        if (pop_cyc[(pop_base + L - 1) % 4096] - pop_cyc[pop_base % 4096] != L - 1) begin
          bad++;
          $display("FAIL load_span: got %0d want %0d", pop_cyc[(pop_base + L - 1) % 4096] - pop_cyc[pop_base % 4096], L - 1);
        end
      end
    end
    done_q = done;
  end

  function automatic words_t rnd_words();
    words_t w;
    for (int i = 0; i < NW; i++) w[i] = W'($urandom);
    return w;
  endfunction

  // reference: bitstream is the words MSB-first, truncated to L; bit j lands at flop L-1-j
  task automatic push_stream(input words_t w, input int flip_k);
    bit s [L];
    for (int j = 0; j < L; j++) s[j] = w[j / W][W - 1 - (j % W)];
    for (int j = 0; j < L; j++) exp_q.push_back(s[j]);
`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    if (flip_k >= 0) s[flip_k] = !s[flip_k];
    for (int j = 0; j < L; j++) exp_q.push_back(s[j]);
    flip_at = (flip_k >= 0) ? shift_n + L + flip_k : -1;
    exp_err = (flip_k >= 0);
`else
    exp_err = 1'b0;
`endif
    for (int j = 0; j < L; j++) exp_chain[L - 1 - j] = s[j];
  endtask

  task automatic run(input words_t w, input int gap, input bit mid_start, input int flip_k);
    int t;
    pop_base = npop;
    acc_base = acc_n;
    chk_span = (gap == 0) && !mid_start;
    push_stream(w, flip_k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < NW; i++) begin
      if (i > 0 && mid_start) begin
        cfg.cfg_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if (i > 0 && gap > 0) begin
        cfg.cfg_valid = 1'b0;
        repeat (gap) @(negedge clk);
      end
      cfg.cfg_word  = w[i];
      cfg.cfg_valid = 1'b1;
      t = 0;
      while (!cfg.cfg_ready) begin
        @(negedge clk);
        if (++t > 100) begin $display("FAIL ready_timeout: word %0d", i); $fatal(1); end
      end
      @(negedge clk);
    end
    cfg.cfg_valid = 1'b0;
    t = 0;
    while (!done) begin
      @(negedge clk);
      if (++t > 200) begin $display("FAIL done_timeout: got done=0 want 1"); $fatal(1); end
    end
    @(negedge clk);
    flip_at = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    words_t w;
    cfg.cfg_word  = '0;
    cfg.cfg_valid = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    run('{8'hA5, 8'hC0}, 0, 1'b0, -1);
    run('{8'hA5, 8'hC0}, 3, 1'b0, -1);
    run(rnd_words(), 0, 1'b1, -1);

    // reset in the middle of a load, then a fresh full load
    w = rnd_words();
    push_stream(w, -1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cfg.cfg_word  = w[0];
    cfg.cfg_valid = 1'b1;
    @(negedge clk);
    cfg.cfg_valid = 1'b0;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 resetn = 1'b0;
    exp_q.delete();
    flip_at = -1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    run(rnd_words(), 0, 1'b0, -1);

    for (int r = 0; r < 6; r++) run(rnd_words(), int'($urandom_range(0, 12)), 1'b0, -1);

`ifdef CCFF_CHAIN_LOADER_READBACK_EN
    run(rnd_words(), 0, 1'b0, int'($urandom_range(0, L - 1)));
    run(rnd_words(), 2, 1'b0, -1);
    run(rnd_words(), 0, 1'b0, 0);
    run(rnd_words(), 0, 1'b0, L - 1);
    run(rnd_words(), 0, 1'b0, -1);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Upstream stage of the configuration-chain flops in routing tiles (connection/switch blocks).
- Accepts bitstream words over a valid/ready interface and serialises them onto the chain's ccff_head.
- Drives an enable to the chain's external clock gate, so the chain advances only when a valid bit is presented.
- Optionally re-circulates the chain to verify the load via CRC.

Parameters:
- CHAIN_LEN, 10, total configuration bits in the attached chain (>=1).
- WORD_W, 8, bitstream word width (>=1).
- CNT_W, 16, width of bit counters; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- prog_clk  input  1  programming clock; all state on rising edge.
- prog_resetn  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load when idle.
- cfg_word  input  WORD_W  bitstream word; MSB is shifted first.
- cfg_valid  input  1  cfg_word valid.
- cfg_ready  output  1  loader can accept cfg_word.
- ccff_head  output  1  serial bit into the chain head.
- ccff_tail  input  1  serial bit returning from the chain tail.
- chain_clk_en  output  1  enable for the external ICG on the chain's prog_clk; the chain shifts at each rising edge where this is 1.
- busy  output  1  load or verify in progress.
- done  output  1  load finished; level signal.
- error  output  1  verify mismatch; level signal. Constant 0 without the optional feature.

Behaviour:
- Reset (asynchronous, prog_resetn=0):
  - state=IDLE.
  - cfg_ready=0, ccff_head=0, chain_clk_en=0, busy=0, done=0, error=0.
  - Word buffers are emptied and counters cleared.
- States and transitions:
  - IDLE -> LOAD on start. On entry: done and error clear, busy=1, bit counter=0.
  - LOAD: a shift register holds the active word plus a one-word prefetch buffer.
    - cfg_ready=1 while the prefetch buffer is empty or draining this cycle.
    - A word is accepted on cfg_valid&cfg_ready.
    - Each cycle the shift register holds a bit: ccff_head=that bit, chain_clk_en=1, counter increments.
    - With no bit available: chain_clk_en=0 and ccff_head holds its value (bubble). No bit is ever duplicated or dropped.
    - With cfg_valid held high, throughput is one bit per cycle, no bubbles.
  - End of LOAD: when the counter reaches CHAIN_LEN.
    - Remaining bits of the final word (ceil(CHAIN_LEN/WORD_W) words total) are discarded.
    - cfg_ready drops the cycle after the final word is accepted.
    - Next state: VERIFY if the feature is enabled, else DONE.
- Bit order: the first bit shifted ends at the tail-most flop. The bitstream generator orders words accordingly.
- ccff_head and chain_clk_en are registered outputs in LOAD.
- DONE: busy=0, done=1, chain_clk_en=0. Returns to IDLE in the same cycle. done/error hold until the next accepted start.
- start is ignored while busy=1.
- cfg_valid outside LOAD is ignored (cfg_ready=0).
- Reset mid-load: immediate return to IDLE. Chain contents are undefined and a full reload is required.

Optional Feature:
- Macro: CCFF_CHAIN_LOADER_READBACK_EN.
- Enabled:
  - In LOAD, a CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, bit-serial) is computed over the CHAIN_LEN shifted bits.
  - VERIFY lasts exactly CHAIN_LEN cycles:
    - chain_clk_en=1.
    - ccff_head=ccff_tail combinationally, so the chain re-circulates and is restored.
    - A second CRC is computed over the ccff_tail samples.
  - After the last cycle, error=(crc_load != crc_readback), then DONE.
  - Reset in VERIFY: chain contents undefined.
- Disabled: no VERIFY state, no CRC logic, error tied 0.

Test Plan:
- Basic load (CHAIN_LEN=10, WORD_W=8): words 0xA5 then 0xC0 with cfg_valid held -> ccff_head sequence 1,0,1,0,0,1,0,1,1,1 on 10 consecutive chain_clk_en=1 cycles; exactly 2 words accepted; done=1 and busy=0 after the final bit (plus 10 VERIFY cycles if enabled).
- Backpressure: deassert cfg_valid for 3 cycles after the first word -> chain_clk_en=0 during the bubble after bit 8; the chain model holds the same final 10 bits as the basic load.
- start pulsed at bit 4 during LOAD -> ignored; exactly 10 chain shifts total; single done.
- prog_resetn low at bit 5 -> all outputs 0 immediately; a subsequent start with a fresh bitstream loads correctly.
- Readback (feature on) with a 10-flop chain model -> error=0; chain contents after VERIFY equal the post-LOAD contents.
- Readback with the model flipping one tail bit during VERIFY -> error=1, done=1. A following start clears error; a clean reload gives error=0.
